// File: rtl/noise_gate_pkg.sv
// noise_gate_pkg: shared gate state encoding, unity gain and saturating level helpers
package noise_gate_pkg;
  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } state_t;
  function automatic int unity(input int frac);
    return 1 << frac;
  endfunction
  // The most negative w-bit value has no positive twin, so it clips to the largest positive one.
  function automatic int sat_abs(input int x, input int w);
    return (x == -(1 << (w - 1))) ? (1 << (w - 1)) - 1 : (x < 0 ? -x : x);
  endfunction
endpackage

// File: rtl/gain_apply.sv
// gain_apply: registered signed sample-times-gain with arithmetic shift and bypass mux
module gain_apply #(
  parameter int WIDTH     = 16,
  parameter int GAIN_FRAC = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    bypass,
  input  logic signed [WIDTH-1:0] sample,
  input  logic [GAIN_FRAC:0]      gain,
  output logic signed [WIDTH-1:0] out_sample
);
  localparam int P = WIDTH + GAIN_FRAC + 2;
  logic signed [P-1:0] prod;
  assign prod = P'(sample) * P'($signed({1'b0, gain}));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_sample <= '0;
    else if (en) out_sample <= bypass ? sample : WIDTH'(prod >>> GAIN_FRAC);
endmodule

// File: rtl/noise_gate_ramp.sv
// noise_gate_ramp: hysteresis noise gate with hold timer and linear attack/release gain ramps
module noise_gate_ramp
  import noise_gate_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int OPEN_THRESH  = 1000,
  parameter int CLOSE_THRESH = 600,
  parameter int HOLD_TIME    = 3000,
  parameter int GAIN_FRAC    = 8,
  parameter int ATTACK_STEP  = 64,
  parameter int RELEASE_STEP = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_sample,
  input  logic                    bypass,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_sample,
  output logic                    gate_open,
  output logic [GAIN_FRAC:0]      gain
);
  localparam int UNITY = unity(GAIN_FRAC);
  localparam int GW    = GAIN_FRAC + 1;
  localparam int HW    = $clog2(HOLD_TIME + 1);
  state_t        state;
  logic [HW-1:0] hold_cnt;
  int            lvl, up, dn;
  logic          loud, quiet;
  logic [GW-1:0] gain_up, gain_dn;
  assign lvl     = sat_abs(int'(in_sample), WIDTH);
  assign loud    = lvl > OPEN_THRESH;
  assign quiet   = lvl <= CLOSE_THRESH;
  assign up      = int'(gain) + ATTACK_STEP;
  assign dn      = int'(gain) - RELEASE_STEP;
  assign gain_up = up >= UNITY ? GW'(UNITY) : GW'(up);
  assign gain_dn = dn <= 0 ? '0 : GW'(dn);
  gain_apply #(.WIDTH(WIDTH), .GAIN_FRAC(GAIN_FRAC)) u_gain_apply (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (in_valid),
    .bypass    (bypass),
    .sample    (in_sample),
    .gain      (gain),
    .out_sample(out_sample)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      state     <= CLOSED;
      gain      <= '0;
      hold_cnt  <= '0;
      gate_open <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        case (state)
          CLOSED: if (loud) begin
            state     <= ATTACK;
            gain      <= gain_up;
            gate_open <= 1'b1;
          end
          ATTACK: begin
            gain <= gain_up;
            if (int'(gain_up) == UNITY) state <= OPEN;
          end
          OPEN: begin
            state    <= quiet ? HOLD : OPEN;
            hold_cnt <= quiet ? HW'(1) : '0;
          end
          HOLD:
            if (!quiet) begin
              state    <= OPEN;
              hold_cnt <= '0;
            end else if (hold_cnt == HW'(HOLD_TIME)) begin
              state     <= gain_dn == '0 ? CLOSED : RELEASE;
              gain      <= gain_dn;
              hold_cnt  <= '0;
              gate_open <= 1'b0;
            end else hold_cnt <= hold_cnt + 1'b1;
          RELEASE:
            if (loud) begin
              state     <= ATTACK;
              gain      <= gain_up;
              gate_open <= 1'b1;
            end else begin
              gain <= gain_dn;
              if (gain_dn == '0) state <= CLOSED;
            end
          default: begin
            state     <= CLOSED;
            gain      <= '0;
            hold_cnt  <= '0;
            gate_open <= 1'b0;
          end
        endcase
    end
endmodule

// File: tb/tb_noise_gate_ramp.sv
// tb_noise_gate_ramp: directed vectors with hand-computed expectations for noise_gate_ramp
module tb_noise_gate_ramp;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, bypass = 1'b0;
  logic signed [15:0] in_sample = '0;
  logic out_valid, gate_open;
  logic signed [15:0] out_sample;
  logic [8:0] gain;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  noise_gate_ramp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sample (in_sample),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_sample(out_sample),
    .gate_open (gate_open),
    .gain      (gain)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic send(input int x);
    @(negedge clk);
    in_valid  = 1'b1;
    in_sample = 16'(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic send_n(input int x, input int n);
    for (int i = 0; i < n; i++) send(x);
  endtask
  task automatic pulse_reset;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask
  int ao[6] = '{0, 500, 1000, 1500, 2000, 2000};
  int ag[6] = '{64, 128, 192, 256, 256, 256};
  int g;
  initial begin
    in_valid  = 1'b1;
    in_sample = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", int'(out_sample), 0);
    check("rst_gain", int'(gain), 0);
    check("rst_gate", int'(gate_open), 0);
    check("rst_valid", int'(out_valid), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(500);
      check("below_out", int'(out_sample), 0);
      check("below_gain", int'(gain), 0);
    end
    check("below_state", int'(dut.state), 0);
    check("below_gate", int'(gate_open), 0);
    for (int i = 0; i < 6; i++) begin
      send(2000);
      check("atk_out", int'(out_sample), ao[i]);
      check("atk_gain", int'(gain), ag[i]);
      check("atk_state", int'(dut.state), i < 3 ? 1 : 2);
    end
    for (int i = 0; i < 5000; i++) begin
      send(700);
      check("band_out", int'(out_sample), 700);
      check("band_gate", int'(gate_open), 1);
    end
    for (int i = 0; i < 3000; i++) begin
      send(100);
      check("hold_out", int'(out_sample), 100);
      check("hold_gate", int'(gate_open), 1);
    end
    check("hold_state", int'(dut.state), 3);
    send(100);
    check("rel1_out", int'(out_sample), 100);
    check("rel1_gain", int'(gain), 252);
    check("rel1_state", int'(dut.state), 4);
    check("rel1_gate", int'(gate_open), 0);
    g = 252;
    for (int k = 2; k <= 64; k++) begin
      send(100);
      check("rel_out", int'(out_sample), (100 * g) >> 8);
      g -= 4;
      check("rel_gain", int'(gain), g);
    end
    check("rel_end_state", int'(dut.state), 0);
    send(100);
    check("closed_out", int'(out_sample), 0);
    send_n(2000, 4);
    check("reopen_state", int'(dut.state), 2);
    send_n(100, 3001);
    check("rt_gain252", int'(gain), 252);
    send_n(100, 31);
    check("rt_gain128", int'(gain), 128);
    check("rt_rel_state", int'(dut.state), 4);
    send(1500);
    check("rt_out", int'(out_sample), 750);
    check("rt_state", int'(dut.state), 1);
    check("rt_gain", int'(gain), 192);
    send(1500);
    check("rt2_out", int'(out_sample), 1125);
    check("rt2_gain", int'(gain), 256);
    check("rt2_state", int'(dut.state), 2);
    pulse_reset;
    check("neg_rst_state", int'(dut.state), 0);
    send(-32768);
    check("neg_out0", int'(out_sample), 0);
    check("neg_gain0", int'(gain), 64);
    check("neg_state0", int'(dut.state), 1);
    send(-32768);
    check("neg_out1", int'(out_sample), -8192);
    send(-32768);
    check("neg_out2", int'(out_sample), -16384);
    send(-32768);
    check("neg_out3", int'(out_sample), -24576);
    check("neg_state3", int'(dut.state), 2);
    send(-32768);
    check("neg_unity", int'(out_sample), -32768);
    @(negedge clk);
    in_valid  = 1'b1;
    in_sample = 16'd5000;
    @(posedge clk);
    #1;
    check("tog_v1", int'(out_valid), 1);
    check("tog_o1", int'(out_sample), 5000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      in_sample = 16'd100;
      @(posedge clk);
      #1;
      check("tog_v0", int'(out_valid), 0);
      check("tog_hold_out", int'(out_sample), 5000);
      check("tog_state", int'(dut.state), 2);
    end
    @(negedge clk);
    in_valid  = 1'b1;
    in_sample = 16'd5000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("tog_v4", int'(out_valid), 1);
    check("tog_state4", int'(dut.state), 2);
    pulse_reset;
    bypass = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(2000);
      check("byp_out", int'(out_sample), 2000);
      check("byp_gain", int'(gain), 64 * (i + 1));
      check("byp_state", int'(dut.state), 1);
    end
    bypass = 1'b0;
    send(2000);
    check("mid_open", int'(dut.state), 2);
    send_n(100, 5);
    check("mid_hold", int'(dut.state), 3);
    check("mid_out", int'(out_sample), 100);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", int'(out_sample), 0);
    check("arst_gain", int'(gain), 0);
    check("arst_gate", int'(gate_open), 0);
    check("arst_valid", int'(out_valid), 0);
    check("arst_state", int'(dut.state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
